// File: rtl/gift_ks_engine_if.sv
// Key-load, run-control and round-key stream signals of the GIFT key-schedule engine.
// master: the core that loads keys, starts runs and consumes round keys.
// slave: the engine itself.
interface gift_ks_engine_if;
    logic        key_wr;
    logic [1:0]  key_idx;
    logic [31:0] key_wdata;
    logic        start;
    logic        abort;
    logic        busy;
    logic        rk_valid;
    logic        rk_ready;
    logic [31:0] rk_u;
    logic [31:0] rk_v;
    logic [5:0]  rk_rc;
    logic [5:0]  rk_round;
    logic        rk_last;

    modport master (
        output key_wr, key_idx, key_wdata, start, abort, rk_ready,
        input  busy, rk_valid, rk_u, rk_v, rk_rc, rk_round, rk_last
    );

    modport slave (
        input  key_wr, key_idx, key_wdata, start, abort, rk_ready,
        output busy, rk_valid, rk_u, rk_v, rk_rc, rk_round, rk_last
    );
endinterface

// File: rtl/gift_ks_engine.sv
// Iterative GIFT-64/128 key schedule: streams one round key per cycle from a 128-bit master key.
// Latency: first round key valid one cycle after start; then one key per accepted handshake.
// Backpressure: rk_ready low freezes all round-key outputs and the working key.
module gift_ks_engine #(
    parameter int VARIANT = 128,
    parameter int NROUNDS = 40
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    gift_ks_engine_if.slave ks
);

    localparam logic [5:0] LAST_ROUND = 6'(NROUNDS - 1);

    // Catch unsupported configurations at elaboration rather than in silicon.
    if (!(VARIANT == 128 || VARIANT == 64)) begin : g_bad_variant
        $error("gift_ks_engine: VARIANT must be 64 or 128");
    end
    if (NROUNDS < 1 || NROUNDS > 63) begin : g_bad_nrounds
        $error("gift_ks_engine: NROUNDS must be in 1..63");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    logic [127:0] mk;
    logic [127:0] wk;
    logic         busy_q;
    logic         valid_q;
    logic [31:0]  u_q;
    logic [31:0]  v_q;
    logic [5:0]   rc_q;
    logic [5:0]   round_q;
    logic         last_q;
    logic         hs;

    // Word rotation k7..k0 <= (k1 ror 2, k0 ror 12, k7, k6, k5, k4, k3, k2); same for both variants.
    function automatic logic [127:0] key_update(input logic [127:0] k);
        logic [15:0] k0;
        logic [15:0] k1;
        k0 = k[15:0];
        k1 = k[31:16];
        return {k1[1:0], k1[15:2], k0[11:0], k0[15:12], k[127:32]};
    endfunction

    // 6-bit LFSR of the GIFT round constant.
    function automatic logic [5:0] rc_next(input logic [5:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    // Round-key extraction, returned as {U, V}; GIFT-64 keys are zero-extended 16-bit words.
    function automatic logic [63:0] extract(input logic [127:0] k);
        if (VARIANT == 128) begin
            return {k[95:64], k[31:0]};
        end
        return {16'h0000, k[31:16], 16'h0000, k[15:0]};
    endfunction

    assign hs = valid_q & ks.rk_ready;

    // Control FSM together with key storage and the registered round-key outputs.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state   <= IDLE;
            mk      <= '0;
            wk      <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            u_q     <= '0;
            v_q     <= '0;
            rc_q    <= '0;
            round_q <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Master key is only writable between runs.
                    if (ks.key_wr) begin
                        mk[{ks.key_idx, 5'b00000} +: 32] <= ks.key_wdata;
                    end
                    if (ks.start && !ks.abort) begin
                        wk         <= key_update(mk);
                        {u_q, v_q} <= extract(mk);
                        rc_q       <= rc_next(6'h00);
                        round_q    <= 6'h00;
                        last_q     <= (LAST_ROUND == 6'h00);
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over any handshake landing on the same edge.
                    if (ks.abort) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (hs) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            wk         <= key_update(wk);
                            {u_q, v_q} <= extract(wk);
                            rc_q       <= rc_next(rc_q);
                            round_q    <= round_q + 6'h01;
                            last_q     <= ((round_q + 6'h01) == LAST_ROUND);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ks.busy     = busy_q;
    assign ks.rk_valid = valid_q;
    assign ks.rk_u     = u_q;
    assign ks.rk_v     = v_q;
    assign ks.rk_rc    = rc_q;
    assign ks.rk_round = round_q;
    assign ks.rk_last  = last_q;

endmodule

// File: tb/tb_gift_ks_engine.sv
// Directed self-checking bench for gift_ks_engine: GIFT-128 (40 rounds) and GIFT-64 (28 rounds).
// Inputs are driven and outputs sampled on the falling clock edge.
// Round keys are checked against hand-computed vectors and a small key-schedule model.
module tb_gift_ks_engine;

    localparam int NR128 = 40;
    localparam int NR64  = 28;

    logic g_clk;
    logic g_resetn;

    gift_ks_engine_if if128();
    gift_ks_engine_if if64();

    gift_ks_engine #(.VARIANT(128), .NROUNDS(NR128)) u_dut128 (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .ks       (if128)
    );

    gift_ks_engine #(.VARIANT(64), .NROUNDS(NR64)) u_dut64 (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .ks       (if64)
    );

    always #5 g_clk = ~g_clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [5:0] rc_tab [0:6] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ku(input logic [127:0] k);
        logic [15:0] w0;
        logic [15:0] w1;
        w0 = k[15:0];
        w1 = k[31:16];
        return {w1[1:0], w1[15:2], w0[11:0], w0[15:12], k[127:32]};
    endfunction

    function automatic logic [5:0] rcn(input logic [5:0] c);
        return {c[4:0], ~(c[5] ^ c[4])};
    endfunction

    task automatic write128(input logic [1:0] idx, input logic [31:0] dat);
        @(negedge g_clk);
        if128.key_wr = 1'b1; if128.key_idx = idx; if128.key_wdata = dat;
        @(negedge g_clk);
        if128.key_wr = 1'b0;
    endtask

    task automatic write64(input logic [1:0] idx, input logic [31:0] dat);
        @(negedge g_clk);
        if64.key_wr = 1'b1; if64.key_idx = idx; if64.key_wdata = dat;
        @(negedge g_clk);
        if64.key_wr = 1'b0;
    endtask

    task automatic check_out128(input string tn, input int r, input logic [31:0] eu,
                                input logic [31:0] ev, input logic [5:0] erc);
        check($sformatf("%s r%0d valid", tn, r), 64'(if128.rk_valid), 64'(1));
        check($sformatf("%s r%0d busy", tn, r),  64'(if128.busy), 64'(1));
        check($sformatf("%s r%0d u", tn, r),     64'(if128.rk_u), 64'(eu));
        check($sformatf("%s r%0d v", tn, r),     64'(if128.rk_v), 64'(ev));
        check($sformatf("%s r%0d rc", tn, r),    64'(if128.rk_rc), 64'(erc));
        check($sformatf("%s r%0d round", tn, r), 64'(if128.rk_round), 64'(r));
        check($sformatf("%s r%0d last", tn, r),  64'(if128.rk_last), 64'(r == NR128 - 1));
    endtask

    task automatic check_zero128(input string tn);
        check({tn, " valid"}, 64'(if128.rk_valid), 64'(0));
        check({tn, " busy"},  64'(if128.busy), 64'(0));
        check({tn, " u"},     64'(if128.rk_u), 64'(0));
        check({tn, " v"},     64'(if128.rk_v), 64'(0));
        check({tn, " rc"},    64'(if128.rk_rc), 64'(0));
        check({tn, " round"}, 64'(if128.rk_round), 64'(0));
        check({tn, " last"},  64'(if128.rk_last), 64'(0));
    endtask

    // One GIFT-128 run: optional random stalls, mid-run write+start injection, abort or reset.
    task automatic run128(input string tn, input logic [127:0] mk, input bit key1_hand,
                          input bit stall, input int inj_r, input int abort_r, input int reset_r);
        logic [127:0] wk;
        logic [5:0]   rc;
        wk = mk;
        rc = 6'h00;
        @(negedge g_clk);
        if128.start = 1'b1;
        @(negedge g_clk);
        if128.start = 1'b0;
        for (int r = 0; r < NR128; r++) begin
            rc = rcn(rc);
            check_out128(tn, r, wk[95:64], wk[31:0], rc);
            if (r < 7) check($sformatf("%s r%0d rc_tab", tn, r), 64'(if128.rk_rc), 64'(rc_tab[r]));
            if (key1_hand && r == 0) check({tn, " hand r0 v"}, 64'(if128.rk_v), 64'h1);
            if (key1_hand && r == 1) check({tn, " hand r1 uv"}, {if128.rk_u, if128.rk_v}, 64'h0);
            if (key1_hand && r == 2) check({tn, " hand r2 uv"}, {if128.rk_u, if128.rk_v}, 64'h0000_0010_0000_0000);
            if (r == reset_r) begin
                g_resetn = 1'b0;
                #1;
                check_zero128({tn, " async reset"});
                @(negedge g_clk);
                g_resetn = 1'b1;
                if128.rk_ready = 1'b0;
                return;
            end
            if (r == abort_r) begin
                if128.abort = 1'b1;
                if128.rk_ready = 1'b1;
                @(negedge g_clk);
                if128.abort = 1'b0;
                if128.rk_ready = 1'b0;
                check({tn, " abort valid"}, 64'(if128.rk_valid), 64'(0));
                check({tn, " abort busy"},  64'(if128.busy), 64'(0));
                return;
            end
            if (stall && ($urandom_range(0, 1) == 1)) begin
                if128.rk_ready = 1'b0;
                repeat ($urandom_range(1, 5)) begin
                    @(negedge g_clk);
                    check_out128({tn, " stall"}, r, wk[95:64], wk[31:0], rc);
                end
            end
            if (r == inj_r) begin
                if128.key_wr = 1'b1; if128.key_idx = 2'd0; if128.key_wdata = 32'hFFFF_FFFF;
                if128.start = 1'b1;
            end
            if128.rk_ready = 1'b1;
            @(negedge g_clk);
            if128.key_wr = 1'b0;
            if128.start = 1'b0;
            wk = ku(wk);
        end
        if128.rk_ready = 1'b0;
        check({tn, " end valid"}, 64'(if128.rk_valid), 64'(0));
        check({tn, " end busy"},  64'(if128.busy), 64'(0));
        check({tn, " end round hold"}, 64'(if128.rk_round), 64'(NR128 - 1));
        @(negedge g_clk);
        check({tn, " idle valid"}, 64'(if128.rk_valid), 64'(0));
    endtask

    task automatic run64(input string tn, input logic [127:0] mk);
        logic [127:0] wk;
        logic [5:0]   rc;
        wk = mk;
        rc = 6'h00;
        @(negedge g_clk);
        if64.start = 1'b1;
        if64.rk_ready = 1'b1;
        @(negedge g_clk);
        if64.start = 1'b0;
        for (int r = 0; r < NR64; r++) begin
            rc = rcn(rc);
            check($sformatf("%s r%0d valid", tn, r), 64'(if64.rk_valid), 64'(1));
            check($sformatf("%s r%0d u", tn, r),     64'(if64.rk_u), {48'h0, wk[31:16]});
            check($sformatf("%s r%0d v", tn, r),     64'(if64.rk_v), {48'h0, wk[15:0]});
            check($sformatf("%s r%0d rc", tn, r),    64'(if64.rk_rc), 64'(rc));
            check($sformatf("%s r%0d round", tn, r), 64'(if64.rk_round), 64'(r));
            check($sformatf("%s r%0d last", tn, r),  64'(if64.rk_last), 64'(r == NR64 - 1));
            if (r == 0) check({tn, " hand r0 v"}, 64'(if64.rk_v), 64'h1);
            if (r == 4) begin
                check({tn, " hand r4 uv"}, {if64.rk_u, if64.rk_v}, 64'h0000_0000_0000_0010);
                check({tn, " hand r4 rc"}, 64'(if64.rk_rc), 64'h1F);
            end
            @(negedge g_clk);
            wk = ku(wk);
        end
        if64.rk_ready = 1'b0;
        check({tn, " end valid"}, 64'(if64.rk_valid), 64'(0));
        check({tn, " end busy"},  64'(if64.busy), 64'(0));
    endtask

    initial begin
        g_clk = 1'b0;
        g_resetn = 1'b0;
        if128.key_wr = 1'b0; if128.key_idx = 2'd0; if128.key_wdata = 32'h0;
        if128.start = 1'b0; if128.abort = 1'b0; if128.rk_ready = 1'b0;
        if64.key_wr = 1'b0; if64.key_idx = 2'd0; if64.key_wdata = 32'h0;
        if64.start = 1'b0; if64.abort = 1'b0; if64.rk_ready = 1'b0;
        #2;
        check_zero128("reset128");
        check("reset64 valid", 64'(if64.rk_valid), 64'(0));
        check("reset64 busy",  64'(if64.busy), 64'(0));
        check("reset64 uv",    {if64.rk_u, if64.rk_v}, 64'h0);
        @(negedge g_clk);
        g_resetn = 1'b1;

        // Abort in IDLE, even with a coincident start, leaves the engine idle.
        @(negedge g_clk);
        if128.abort = 1'b1; if128.start = 1'b1;
        @(negedge g_clk);
        if128.abort = 1'b0; if128.start = 1'b0;
        check("idle abort+start busy",  64'(if128.busy), 64'(0));
        check("idle abort+start valid", 64'(if128.rk_valid), 64'(0));

        // All-zero master key, consumer always ready.
        if128.rk_ready = 1'b1;
        run128("t1", 128'h0, 1'b0, 1'b0, -1, -1, -1);

        // Single set bit in k0.
        write128(2'd0, 32'h0000_0001);
        write128(2'd1, 32'h0);
        write128(2'd2, 32'h0);
        write128(2'd3, 32'h0);
        if128.rk_ready = 1'b1;
        run128("t2", 128'h1, 1'b1, 1'b0, -1, -1, -1);

        // GIFT-64 with the same key.
        write64(2'd0, 32'h0000_0001);
        run64("t3", 128'h1);

        // Random backpressure.
        run128("t4", 128'h1, 1'b1, 1'b1, -1, -1, -1);

        // Ignored write and start mid-run, abort at round 5, then a clean restart.
        run128("t5a", 128'h1, 1'b1, 1'b0, 2, 5, -1);
        run128("t5b", 128'h1, 1'b1, 1'b0, -1, -1, -1);

        // Async reset mid-run clears the master key: the next run streams zeros.
        run128("t6a", 128'h1, 1'b1, 1'b0, -1, -1, 10);
        run128("t6b", 128'h0, 1'b0, 1'b0, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/gift_ks_engine.md
Name: gift_ks_engine

Overview:
Iterative GIFT key-schedule engine. It holds a 128-bit master key, loaded as 32-bit words from the core, and streams one round key per cycle over a valid/ready interface. The same datapath serves GIFT-64 and GIFT-128, selected by parameter. It runs alongside the GIFT ISE datapath, so software no longer computes the key schedule with per-instruction key-update ops.

Parameters:
VARIANT   128   GIFT variant: 128 or 64; any other value is illegal (elaboration error).
NROUNDS   40    number of round keys per run; legal 1..63; use 28 for GIFT-64.

Ports:
g_clk      in   1   clock, rising edge.
g_resetn   in   1   reset; asynchronous, active-low.
key_wr     in   1   write one master-key word this cycle.
key_idx    in   2   word index: 0 = key[31:0] (k1||k0) ... 3 = key[127:96] (k7||k6).
key_wdata  in   32  master-key word.
start      in   1   single-cycle pulse: begin a run.
abort      in   1   synchronous cancel of a run.
busy       out  1   high while a run is in progress.
rk_valid   out  1   round-key output valid.
rk_ready   in   1   consumer accepts the round key.
rk_u       out  32  U word (GIFT-64: zero-extended 16 bits).
rk_v       out  32  V word (GIFT-64: zero-extended 16 bits).
rk_rc      out  6   round constant for this round.
rk_round   out  6   round index, 0..NROUNDS-1.
rk_last    out  1   high when rk_round == NROUNDS-1.

Behaviour:
- Storage: master key register MK (128b) and working key WK (128b), both viewed as 16-bit words k7..k0 with k0 = bits 15:0.
- Reset values: MK=0, WK=0, rc state=0, round=0, busy=0, rk_valid=0, rk_u=rk_v=0, rk_rc=0, rk_round=0, rk_last=0. FSM is in IDLE.
- FSM states:
  - IDLE: key_wr writes MK word key_idx at the clock edge.
  - IDLE -> RUN on start, provided abort is low.
  - RUN -> IDLE after the handshake on the last round, or on abort.
- Writes and starts while busy: key_wr is ignored whenever busy=1; MK is never modified during RUN. start is ignored while busy=1.
- Start (edge t):
  - WK <= key_update(MK).
  - Output register loaded with round 0: U/V extracted from MK, rk_rc=0x01, rk_round=0.
  - rk_valid=1 and busy=1 from after edge t. Latency start->rk_valid is 1 cycle.
- Extraction:
  - GIFT-128: U = k5||k4, V = k1||k0.
  - GIFT-64: U = {16'h0,k1}, V = {16'h0,k0}.
- key_update: (k7,k6,k5,k4,k3,k2,k1,k0) <= (k1 ror16 2, k0 ror16 12, k7, k6, k5, k4, k3, k2). Identical for both variants.
- Round constant: c' = {c[4:0], c[5]^c[4]^1}. The round-0 constant is c'(0)=0x01. Sequence 01,03,07,0F,1F,3E,3D,...
- Handshake (rk_valid & rk_ready) with rk_round < NROUNDS-1:
  - Next edge loads round rk_round+1 from WK and the next rc.
  - WK <= key_update(WK).
  - rk_valid stays 1. Throughput is 1 key/cycle while rk_ready is held high.
- Handshake on rk_last: rk_valid=0 and busy=0 after the edge; FSM returns to IDLE. rk_u/rk_v/rk_rc/rk_round hold their last values.
- Backpressure: while rk_valid=1 and rk_ready=0, all rk_* outputs and WK hold stable.
- abort in RUN: after the next edge, rk_valid=0 and busy=0. MK is unchanged; WK contents are don't-care. abort in IDLE has no effect. abort has priority over start and over a coincident handshake.
- Restart: a new start after completion or abort replays the identical sequence from MK.
- Async reset mid-run: immediate return to reset values; MK is cleared.

Test Plan:
1. VARIANT=128, MK=0, start, rk_ready=1 -> 40 consecutive cycles of rk_valid with U=V=0; rk_rc = 01,03,07,0F,1F,3E,...; rk_last only at round 39; busy falls after that handshake.
2. VARIANT=128, write idx0=0x00000001 (others 0), start -> round 0: V=0x00000001, U=0. Round 1: U=V=0. Round 2: U=0x00000010, V=0, rc=0x07.
3. VARIANT=64, NROUNDS=28, same key -> round 0: V=0x00000001. Round 4: V=0x00000010, U=0, rc=0x1F. rk_last at round 27.
4. Backpressure: drop rk_ready randomly for 1-5 cycles -> outputs stable while stalled; the accepted sequence matches test 2 exactly, with no skipped or duplicated rounds.
5. key_wr to idx0 and a second start mid-run -> both ignored, stream unchanged. abort at round 5 -> rk_valid=0 next cycle. Re-start -> round 0 again matches test 2.
6. Assert g_resetn low mid-run -> all outputs and MK read 0 immediately; after release, start streams the all-zero key sequence of test 1.
